// File: rtl/data_cache_pkg.sv
// Shared geometry, state encodings and helpers for the direct-mapped data cache.
package data_cache_pkg;

  localparam int unsigned CACHE_LINES          = 4;
  localparam int unsigned CACHE_WORDS_PER_LINE = 4;
  localparam int unsigned CACHE_WORD_W         = 32;
  localparam int unsigned CACHE_LINE_W         = CACHE_WORDS_PER_LINE * CACHE_WORD_W;
  localparam int unsigned CACHE_OFFSET_W       = $clog2(CACHE_LINE_W / 8);
  localparam int unsigned CACHE_INDEX_W        = $clog2(CACHE_LINES);
  localparam int unsigned CACHE_TAG_W          = 32 - CACHE_OFFSET_W - CACHE_INDEX_W;
  localparam int unsigned CACHE_WSEL_W         = $clog2(CACHE_WORDS_PER_LINE);

  // Miss-handling controller states
  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StRefill,
    StDone
  } cache_state_e;

  // Operation on the single storage write port
  typedef enum logic [1:0] {
    WrNone,   // no update
    WrFill,   // whole line from backing memory, tag set, valid=1, dirty=0
    WrStore,  // byte-masked word write, dirty=1
    WrClean   // victim written back, dirty=0
  } array_wr_e;

  // Line-aligned byte address from tag and index
  function automatic logic [31:0] line_addr(input logic [CACHE_TAG_W-1:0]   tag,
                                            input logic [CACHE_INDEX_W-1:0] idx);
    return {tag, idx, {CACHE_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Valid/dirty/tag/data storage: one combinational read port and one write port,
// both addressed by the same line index.
module data_cache_array
  import data_cache_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CACHE_INDEX_W-1:0]  idx_i,
  output logic                      valid_o,
  output logic                      dirty_o,
  output logic [CACHE_TAG_W-1:0]    tag_o,
  output logic [CACHE_LINE_W-1:0]   line_o,
  input  array_wr_e                 wr_op_i,
  input  logic [CACHE_WSEL_W-1:0]   wr_word_i,
  input  logic [3:0]                wr_be_i,
  input  logic [CACHE_WORD_W-1:0]   wr_data_i,
  input  logic [CACHE_TAG_W-1:0]    wr_tag_i,
  input  logic [CACHE_LINE_W-1:0]   wr_line_i
);

  logic [CACHE_LINES-1:0]  valid_q;
  logic [CACHE_LINES-1:0]  dirty_q;
  logic [CACHE_TAG_W-1:0]  tag_q  [CACHE_LINES];
  logic [CACHE_LINE_W-1:0] data_q [CACHE_LINES];

  logic [CACHE_LINE_W-1:0] st_mask;
  logic [CACHE_LINE_W-1:0] st_line;

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  // Expand the word select and byte enables into a full-line bit mask
  always_comb begin
    st_mask = '0;
    st_line = {CACHE_WORDS_PER_LINE{wr_data_i}};
    for (int w = 0; w < int'(CACHE_WORDS_PER_LINE); w++) begin
      for (int b = 0; b < 4; b++) begin
        st_mask[w*32 + b*8 +: 8] = {8{wr_be_i[b] & (wr_word_i == CACHE_WSEL_W'(w))}};
      end
    end
  end

  // Status bits: cleared by reset so every line starts invalid and clean
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      unique case (wr_op_i)
        WrFill: begin
          valid_q[idx_i] <= 1'b1;
          dirty_q[idx_i] <= 1'b0;
        end
        WrStore: dirty_q[idx_i] <= 1'b1;
        WrClean: dirty_q[idx_i] <= 1'b0;
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; contents are qualified by valid
  always_ff @(posedge clock) begin
    if (wr_op_i == WrFill) begin
      tag_q[idx_i]  <= wr_tag_i;
      data_q[idx_i] <= wr_line_i;
    end else if (wr_op_i == WrStore) begin
      data_q[idx_i] <= (data_q[idx_i] & ~st_mask) | (st_line & st_mask);
    end
  end

endmodule

// File: rtl/data_cache.sv
// Memory-stage data cache: direct-mapped, write-back, write-allocate. Hits complete in
// the access cycle; misses stall while the controller writes back a dirty victim and
// refills the line over the req/ack backing-memory port.
module data_cache
  import data_cache_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         m_mem_read,
  input  logic         m_mem_write,
  input  logic         m_mem_byte,
  input  logic [31:0]  m_address,
  input  logic [31:0]  m_write_data,
  output logic [31:0]  m_read_data,
  output logic         m_stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [127:0] mem_rdata
);

  cache_state_e state_q, state_d;
  logic         mem_req_q, mem_req_d;
  logic         mem_we_q, mem_we_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [127:0] mem_wdata_q, mem_wdata_d;

  logic [CACHE_TAG_W-1:0]   req_tag;
  logic [CACHE_INDEX_W-1:0] req_idx;
  logic [CACHE_WSEL_W-1:0]  req_word;
  logic [1:0]               req_lane;

  logic                     arr_valid, arr_dirty;
  logic [CACHE_TAG_W-1:0]   arr_tag;
  logic [CACHE_LINE_W-1:0]  arr_line;
  array_wr_e                arr_wr_op;

  logic        access, hit;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [3:0]  st_be;
  logic [31:0] st_data;

  assign req_tag  = m_address[31 -: CACHE_TAG_W];
  assign req_idx  = m_address[CACHE_OFFSET_W +: CACHE_INDEX_W];
  assign req_word = m_address[2 +: CACHE_WSEL_W];
  assign req_lane = m_address[1:0];

  // An access seen while reset is held must neither stall nor touch the arrays
  assign access = (m_mem_read | m_mem_write) & ~reset;
  assign hit    = arr_valid && (arr_tag == req_tag);

  assign rd_word = arr_line[{req_word, 5'b0} +: 32];
  assign rd_byte = rd_word[{req_lane, 3'b0} +: 8];

  // Byte stores replicate the byte; the lane enable picks where it lands
  assign st_be   = m_mem_byte ? (4'b0001 << req_lane) : 4'b1111;
  assign st_data = m_mem_byte ? {4{m_write_data[7:0]}} : m_write_data;

  data_cache_array u_array (
    .clock     (clock),
    .reset     (reset),
    .idx_i     (req_idx),
    .valid_o   (arr_valid),
    .dirty_o   (arr_dirty),
    .tag_o     (arr_tag),
    .line_o    (arr_line),
    .wr_op_i   (arr_wr_op),
    .wr_word_i (req_word),
    .wr_be_i   (st_be),
    .wr_data_i (st_data),
    .wr_tag_i  (req_tag),
    .wr_line_i (mem_rdata)
  );

  // Next state, registered memory-port values, stall, load data and array writes
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    m_stall     = 1'b0;
    m_read_data = '0;
    arr_wr_op   = WrNone;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (hit) begin
            if (m_mem_write) begin
              arr_wr_op = WrStore;
            end else begin
              m_read_data = m_mem_byte ? {24'b0, rd_byte} : rd_word;
            end
          end else begin
            m_stall   = 1'b1;
            mem_req_d = 1'b1;
            if (arr_valid && arr_dirty) begin
              state_d     = StWriteback;
              mem_we_d    = 1'b1;
              mem_addr_d  = line_addr(arr_tag, req_idx);
              mem_wdata_d = arr_line;
            end else begin
              state_d    = StRefill;
              mem_we_d   = 1'b0;
              mem_addr_d = line_addr(req_tag, req_idx);
            end
          end
        end
      end
      StWriteback: begin
        m_stall = 1'b1;
        if (mem_ack) begin
          arr_wr_op = WrClean;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StRefill;
        end
      end
      StRefill: begin
        m_stall = 1'b1;
        // Arriving from write-back the request is low for one cycle; raise it here
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = line_addr(req_tag, req_idx);
        end else if (mem_ack) begin
          arr_wr_op = WrFill;
          mem_req_d = 1'b0;
          state_d   = StDone;
        end
      end
      StDone: begin
        m_stall = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Controller state and registered backing-memory request
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_cache.sv
// Randomized scoreboard bench for data_cache. A flat golden memory gives the expected
// load data; a residency model of the direct-mapped cache predicts misses, write-backs
// and stall counts. A responder plays backing memory and checks the request handshake.
module tb_data_cache;

  logic         clock = 1'b0;
  logic         reset;
  logic         m_mem_read, m_mem_write, m_mem_byte;
  logic [31:0]  m_address, m_write_data, m_read_data;
  logic         m_stall;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         ack_r, late_ack;

  assign mem_ack = ack_r | late_ack;

  data_cache dut (
    .clock        (clock),
    .reset        (reset),
    .m_mem_read   (m_mem_read),
    .m_mem_write  (m_mem_write),
    .m_mem_byte   (m_mem_byte),
    .m_address    (m_address),
    .m_write_data (m_write_data),
    .m_read_data  (m_read_data),
    .m_stall      (m_stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [31:0] gmem [logic [31:0]];  // architectural memory as the pipeline sees it
  logic [31:0] bmem [logic [31:0]];  // backing memory contents
  logic [25:0] rtag   [4];
  bit          rvalid [4];
  bit          rdirty [4];

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [127:0] data;
  } xfer_t;

  xfer_t       xq [$];
  logic [31:0] rq [$];
  int          wb_k = 1;
  int          rf_k = 1;

  task automatic chk(input bit ok, input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] gget(input logic [31:0] wa);
    return gmem.exists(wa) ? gmem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] bget(input logic [31:0] wa);
    return bmem.exists(wa) ? bmem[wa] : init_word(wa);
  endfunction

  function automatic logic [127:0] gline(input logic [31:0] la);
    logic [31:0] wa;
    wa = la >> 2;
    return {gget(wa + 3), gget(wa + 2), gget(wa + 1), gget(wa)};
  endfunction

  function automatic logic [127:0] bline(input logic [31:0] la);
    logic [31:0] wa;
    wa = la >> 2;
    return {bget(wa + 3), bget(wa + 2), bget(wa + 1), bget(wa)};
  endfunction

  // Load data check whenever an access completes
  logic [31:0] mon_exp;
  always @(negedge clock) begin
    if (!reset && (m_mem_read || m_mem_write) && !m_stall) begin
      if (rq.size() == 0) begin
        chk(1'b0, "rdata_unexpected", 128'(m_read_data), 128'(0));
      end else begin
        mon_exp = rq.pop_front();
        chk(m_read_data === mon_exp, "rdata", 128'(m_read_data), 128'(mon_exp));
      end
    end
  end

  // Backing memory: acks each request after k request cycles
  logic [31:0]  r_addr;
  logic         r_we;
  logic [127:0] r_wdata;
  int           r_k;
  bit           r_abort;
  xfer_t        r_exp;
  initial begin
    ack_r     = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (!reset && mem_req) begin
        r_addr  = mem_addr;
        r_we    = mem_we;
        r_wdata = mem_wdata;
        r_k     = r_we ? wb_k : rf_k;
        if (xq.size() == 0) begin
          chk(1'b0, "req_unexpected", 128'(r_addr), 128'(0));
        end else begin
          r_exp = xq.pop_front();
          chk(r_we == r_exp.we, "req_we", 128'(r_we), 128'(r_exp.we));
          chk(r_addr == r_exp.addr, "req_addr", 128'(r_addr), 128'(r_exp.addr));
          if (r_exp.we) chk(r_wdata == r_exp.data, "wb_data", r_wdata, r_exp.data);
        end
        r_abort = 1'b0;
        for (int i = 1; i < r_k; i++) begin
          @(negedge clock);
          if (reset || !mem_req) begin
            r_abort = 1'b1;
            break;
          end
          chk(mem_addr == r_addr && mem_we == r_we && mem_wdata == r_wdata,
              "req_hold", 128'(mem_addr), 128'(r_addr));
        end
        if (!r_abort) begin
          mem_rdata = r_we ? '0 : bline(r_addr);
          ack_r     = 1'b1;
          @(posedge clock);
          #1 ack_r = 1'b0;
          if (r_we) begin
            for (int w = 0; w < 4; w++) bmem[(r_addr >> 2) + w] = r_wdata[w*32 +: 32];
          end
          @(negedge clock);
          chk(mem_req == 1'b0, "req_drop_after_ack", 128'(mem_req), 128'(0));
        end
      end
    end
  end

  // Issue one access (called at posedge+1) and check its stall count
  task automatic do_access(input bit rd, input bit wr, input bit byt, input logic [31:0] addr,
                           input logic [31:0] wdata, input int wk, input int rk);
    logic [1:0]  ix;
    logic [25:0] tg;
    logic [31:0] wa, w, e;
    int          exp_stall, stalls;
    ix   = addr[5:4];
    tg   = addr[31:6];
    wa   = addr >> 2;
    wb_k = wk;
    rf_k = rk;
    if (rvalid[ix] && rtag[ix] == tg) begin
      exp_stall = 0;
    end else begin
      if (rvalid[ix] && rdirty[ix]) begin
        xq.push_back('{1'b1, {rtag[ix], ix, 4'b0}, gline({rtag[ix], ix, 4'b0})});
        exp_stall = wk + rk + 3;
      end else begin
        exp_stall = rk + 2;
      end
      xq.push_back('{1'b0, {tg, ix, 4'b0}, 128'(0)});
      rvalid[ix] = 1'b1;
      rtag[ix]   = tg;
      rdirty[ix] = 1'b0;
    end
    w = gget(wa);
    if (wr) begin
      rq.push_back(32'h0);
      if (byt) begin
        w = (w & ~(32'hFF << {addr[1:0], 3'b0})) | ({24'b0, wdata[7:0]} << {addr[1:0], 3'b0});
      end else begin
        w = wdata;
      end
      gmem[wa]   = w;
      rdirty[ix] = 1'b1;
    end else begin
      e = byt ? ((w >> {addr[1:0], 3'b0}) & 32'hFF) : w;
      rq.push_back(e);
    end
    m_mem_read   = rd;
    m_mem_write  = wr;
    m_mem_byte   = byt;
    m_address    = addr;
    m_write_data = wdata;
    stalls = 0;
    forever begin
      @(negedge clock);
      if (!m_stall) break;
      stalls++;
      if (stalls > 200) begin
        chk(1'b0, "stall_timeout", 128'(stalls), 128'(exp_stall));
        break;
      end
    end
    chk(stalls == exp_stall, "stall_cycles", 128'(stalls), 128'(exp_stall));
    @(posedge clock);
    #1;
    m_mem_read  = 1'b0;
    m_mem_write = 1'b0;
  endtask

  // Dirty contents are lost on reset; the cache comes back empty
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      if (rvalid[i] && rdirty[i]) begin
        for (int w = 0; w < 4; w++) begin
          gmem[({rtag[i], 2'(i), 4'b0} >> 2) + w] = bget(({rtag[i], 2'(i), 4'b0} >> 2) + w);
        end
      end
      rvalid[i] = 1'b0;
      rdirty[i] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [25:0] tlist [4];
  logic [31:0] ra;
  int          kind;

  initial begin
    reset        = 1'b1;
    late_ack     = 1'b0;
    m_mem_read   = 1'b0;
    m_mem_write  = 1'b0;
    m_mem_byte   = 1'b0;
    m_address    = '0;
    m_write_data = '0;
    for (int i = 0; i < 4; i++) begin
      rvalid[i] = 1'b0;
      rdirty[i] = 1'b0;
      rtag[i]   = '0;
    end
    // Line 0x40 = {D3,C2,B1,A0}; word 0x80000040 has a byte 3 with the top bit set
    gmem[32'h10] = 32'hA0; gmem[32'h11] = 32'hB1; gmem[32'h12] = 32'hC2; gmem[32'h13] = 32'hD3;
    bmem[32'h10] = 32'hA0; bmem[32'h11] = 32'hB1; bmem[32'h12] = 32'hC2; bmem[32'h13] = 32'hD3;
    gmem[32'h2000_0010] = 32'h9ABC_DEF0;
    bmem[32'h2000_0010] = 32'h9ABC_DEF0;

    #12;
    chk(m_stall == 1'b0, "rst_stall", 128'(m_stall), 128'(0));
    chk(m_read_data == 32'h0, "rst_rdata", 128'(m_read_data), 128'(0));
    chk(mem_req == 1'b0, "rst_req", 128'(mem_req), 128'(0));
    chk(mem_we == 1'b0, "rst_we", 128'(mem_we), 128'(0));
    chk(mem_addr == 32'h0, "rst_addr", 128'(mem_addr), 128'(0));
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // Cold miss, store-byte hit, dirty eviction, clean re-miss, slow refill
    do_access(1, 0, 0, 32'h40, 32'h0, 1, 1);
    do_access(0, 1, 1, 32'h41, 32'h0000_00AB, 1, 1);
    do_access(1, 0, 0, 32'h40, 32'h0, 1, 1);
    do_access(1, 0, 0, 32'h80, 32'h0, 2, 1);
    do_access(1, 0, 0, 32'h40, 32'h0, 1, 1);
    do_access(1, 0, 0, 32'hC0, 32'h0, 1, 5);

    // Reset during refill abandons the transfer
    xq.push_back('{1'b0, 32'h100, 128'(0)});
    rf_k         = 50;
    m_mem_read   = 1'b1;
    m_mem_byte   = 1'b0;
    m_address    = 32'h100;
    repeat (3) @(negedge clock);
    chk(mem_req == 1'b1, "t5_req_up", 128'(mem_req), 128'(1));
    #2;
    reset      = 1'b1;
    m_mem_read = 1'b0;
    #1;
    chk(mem_req == 1'b0, "t5_req_async_drop", 128'(mem_req), 128'(0));
    chk(mem_addr == 32'h0, "t5_addr_cleared", 128'(mem_addr), 128'(0));
    chk(m_stall == 1'b0, "t5_stall", 128'(m_stall), 128'(0));
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    late_ack = 1'b1;
    @(posedge clock);
    #1 late_ack = 1'b0;
    @(negedge clock);
    chk(mem_req == 1'b0, "t5_late_ack_req", 128'(mem_req), 128'(0));
    chk(m_stall == 1'b0, "t5_late_ack_stall", 128'(m_stall), 128'(0));
    @(posedge clock);
    #1;
    do_access(1, 0, 0, 32'h40, 32'h0, 1, 1);

    // Read+write together acts as a store; then a zero-extended byte load
    do_access(1, 1, 0, 32'h44, 32'h1357_9BDF, 1, 1);
    do_access(1, 0, 0, 32'h44, 32'h0, 1, 1);
    do_access(1, 0, 1, 32'h8000_0043, 32'h0, 2, 2);
    do_access(1, 0, 1, 32'h8000_0043, 32'h0, 1, 1);

    // Randomized mix over a few conflicting tags per index
    tlist[0] = 26'h1;
    tlist[1] = 26'h2;
    tlist[2] = 26'h3;
    tlist[3] = 26'h200_0001;
    for (int n = 0; n < 200; n++) begin
      ra   = {tlist[$urandom_range(0, 3)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3))};
      kind = $urandom_range(0, 9);
      do_access(kind < 5 || kind == 9, kind >= 5, 1'($urandom_range(0, 1)), ra, $urandom,
                $urandom_range(1, 4), $urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock);
        chk(m_stall == 1'b0 && m_read_data == 32'h0 && mem_req == 1'b0, "idle_quiet",
            128'({m_stall, mem_req, m_read_data}), 128'(0));
        @(posedge clock);
        #1;
      end
    end

    repeat (3) @(posedge clock);
    chk(xq.size() == 0, "xfer_queue_drained", 128'(xq.size()), 128'(0));
    chk(rq.size() == 0, "rdata_queue_drained", 128'(rq.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
